// File: rtl/ntt_stage_scheduler.sv
// Stage sequencer for the radix-16 NTT index pipeline: issues one butterfly group
// per cycle and drains the delay pipeline at each stage boundary.
module ntt_stage_scheduler #(
    parameter int GRP_W     = 4,
    parameter int STAGE_NUM = 3,
    parameter int INFL_W    = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         stall,
    input  logic                         retire,
    output logic                         busy,
    output logic                         ntt_issue,
    output logic [GRP_W-1:0]             grp_idx,
    output logic [$clog2(STAGE_NUM)-1:0] stage_idx,
    output logic                         ntt_done,
    output logic                         err
);
    localparam int SW = $clog2(STAGE_NUM);
    localparam logic [SW-1:0]     LAST_STAGE = SW'(STAGE_NUM - 1);
    localparam logic [GRP_W-1:0]  LAST_GRP   = {GRP_W{1'b1}};
    localparam logic [INFL_W-1:0] INFL_MAX   = {INFL_W{1'b1}};
    localparam logic [INFL_W-1:0] INFL_ZERO  = {INFL_W{1'b0}};
    localparam logic [INFL_W-1:0] INFL_ONE   = INFL_W'(1'b1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_r, state_nxt_s;
    logic [INFL_W-1:0] infl_r, infl_nxt_s;
    logic [GRP_W-1:0]  grp_r;
    logic [SW-1:0]     stage_r;
    logic              busy_r, done_r, err_r;
    logic              issue_s, err_set_s;
    logic              grp_clr_s, grp_inc_s, stage_clr_s, stage_inc_s;

    // Next-state and issue decode
    always_comb begin
        state_nxt_s = state_r;
        issue_s     = 1'b0;
        grp_clr_s   = 1'b0;
        grp_inc_s   = 1'b0;
        stage_clr_s = 1'b0;
        stage_inc_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = ISSUE;
                    grp_clr_s   = 1'b1;
                    stage_clr_s = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: begin
                if (!stall) begin
                    issue_s   = 1'b1;
                    grp_inc_s = 1'b1;
                    if (grp_r == LAST_GRP) begin
                        state_nxt_s = DRAIN;
                    end else begin
                        state_nxt_s = ISSUE;
                    end
                end else begin
                    state_nxt_s = ISSUE;
                end
            end
            DRAIN: begin
                // Leave once the in-flight count will be zero after this edge
                if ((infl_r == INFL_ONE && retire) || infl_r == INFL_ZERO) begin
                    if (stage_r == LAST_STAGE) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = ISSUE;
                        stage_inc_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
                stage_clr_s = 1'b1;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // In-flight counter update with underflow/overflow detection
    always_comb begin
        infl_nxt_s = infl_r;
        err_set_s  = 1'b0;
        if (issue_s && !retire) begin
            if (infl_r == INFL_MAX) begin
                err_set_s = 1'b1;
            end else begin
                infl_nxt_s = infl_r + INFL_ONE;
            end
        end else if (retire && !issue_s) begin
            if (infl_r == INFL_ZERO) begin
                err_set_s = 1'b1;
            end else begin
                infl_nxt_s = infl_r - INFL_ONE;
            end
        end else begin
            infl_nxt_s = infl_r;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            infl_r  <= INFL_ZERO;
            grp_r   <= {GRP_W{1'b0}};
            stage_r <= {SW{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            infl_r  <= infl_nxt_s;
            busy_r  <= (state_nxt_s != IDLE);
            done_r  <= (state_nxt_s == DONE);
            err_r   <= err_r | err_set_s;
            if (grp_clr_s) begin
                grp_r <= {GRP_W{1'b0}};
            end else if (grp_inc_s) begin
                grp_r <= grp_r + GRP_W'(1'b1);
            end
            if (stage_clr_s) begin
                stage_r <= {SW{1'b0}};
            end else if (stage_inc_s) begin
                stage_r <= stage_r + SW'(1'b1);
            end
        end
    end

    assign ntt_issue = issue_s;
    assign grp_idx   = grp_r;
    assign stage_idx = stage_r;
    assign busy      = busy_r;
    assign ntt_done  = done_r;
    assign err       = err_r;
endmodule

// File: tb/tb_ntt_stage_scheduler.sv
// Randomized bench for ntt_stage_scheduler: a group/stage accounting model predicts
// every output each cycle; directed runs pin the model with hand-derived cycle numbers.
module tb_ntt_stage_scheduler;
    localparam int NGRP     = 16;
    localparam int NSTAGE   = 3;
    localparam int INFL_MAX = 31;

    logic       clk, rst, start, stall, retire;
    logic       busy, ntt_issue, ntt_done, err;
    logic [3:0] grp_idx;
    logic [1:0] stage_idx;

    ntt_stage_scheduler dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall), .retire(retire),
        .busy(busy), .ntt_issue(ntt_issue), .grp_idx(grp_idx),
        .stage_idx(stage_idx), .ntt_done(ntt_done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int abs_cyc = 0;
    int rel = 0;
    int dly = 12;
    bit hist [64];

    // behavioural model: run progress expressed as groups issued and stages released
    bit m_run, m_done, m_err;
    int m_issued, m_released, m_infl;

    // per-scenario observations of the model
    int first_iss [NSTAGE];
    int last_iss  [NSTAGE];
    int grp_rec   [128];
    int n_iss, n_done, done_cyc, busy_fall;

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        n_chk++;
        if (act !== 32'(exp)) begin
            n_fail++;
            $display("FAIL %s at cycle %0d (rel %0d): got %0d expected %0d", nm, abs_cyc, rel, act, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 1'b0; m_done = 1'b0; m_err = 1'b0;
        m_issued = 0; m_released = 0; m_infl = 0;
    endtask

    task automatic reset_stats();
        rel = 0; n_iss = 0; n_done = 0; done_cyc = -1; busy_fall = -1;
        for (int i = 0; i < NSTAGE; i++) begin
            first_iss[i] = -1;
            last_iss[i]  = -1;
        end
        for (int i = 0; i < 128; i++) grp_rec[i] = -1;
    endtask

    task automatic step(input bit st, input bit sl, input bit xr);
        bit ret, iss_phase, e_issue, e_busy, e_done;
        int e_grp, e_stage, nxt_infl;
        @(negedge clk);
        ret    = hist[(abs_cyc - dly) & 63] | xr;
        start  = st;
        stall  = sl;
        retire = ret;
        #1;
        iss_phase = m_run && (m_issued < NGRP * (m_released + 1));
        e_issue   = iss_phase && !sl;
        e_busy    = m_run || m_done;
        e_done    = m_done;
        e_grp     = m_issued % NGRP;
        e_stage   = m_run ? m_released : (m_done ? NSTAGE - 1 : 0);
        chk("busy", busy, int'(e_busy));
        chk("ntt_issue", ntt_issue, int'(e_issue));
        chk("grp_idx", grp_idx, e_grp);
        chk("stage_idx", stage_idx, e_stage);
        chk("ntt_done", ntt_done, int'(e_done));
        chk("err", err, int'(m_err));
        if (e_issue) begin
            n_iss++;
            if (first_iss[e_stage] < 0) first_iss[e_stage] = rel;
            last_iss[e_stage] = rel;
        end
        if (e_done) begin
            n_done++;
            done_cyc = rel;
        end
        if (done_cyc >= 0 && !e_busy && busy_fall < 0) busy_fall = rel;
        if (rel < 128) grp_rec[rel] = e_grp;
        hist[abs_cyc & 63] = e_issue;
        nxt_infl = m_infl;
        if (e_issue && !ret) begin
            if (m_infl == INFL_MAX) m_err = 1'b1;
            else nxt_infl = m_infl + 1;
        end else if (ret && !e_issue) begin
            if (m_infl == 0) m_err = 1'b1;
            else nxt_infl = m_infl - 1;
        end
        m_infl = nxt_infl;
        if (m_done) begin
            m_done = 1'b0;
        end else if (!m_run) begin
            if (st) begin
                m_run = 1'b1; m_issued = 0; m_released = 0;
            end
        end else if (iss_phase) begin
            if (e_issue) m_issued++;
        end else if (nxt_infl == 0) begin
            m_released++;
            if (m_released == NSTAGE) begin
                m_run  = 1'b0;
                m_done = 1'b1;
            end
        end
        abs_cyc++;
        rel++;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_issue"}, ntt_issue, 0);
        chk({tag, "_grp"}, grp_idx, 0);
        chk({tag, "_stage"}, stage_idx, 0);
        chk({tag, "_done"}, ntt_done, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b0; start = 1'b0; stall = 1'b0; retire = 1'b0;
        #1;
        model_reset();
        check_zero(tag);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; stall = 1'b0; retire = 1'b0;
        model_reset();
        #12;
        check_zero("por");
        @(negedge clk);
        rst = 1'b1;

        // nominal run, pipeline depth 12
        dly = 12; reset_stats();
        step(1'b1, 1'b0, 1'b0);
        repeat (99) step(1'b0, 1'b0, 1'b0);
        chk("nom_first0", first_iss[0], 1);
        chk("nom_last0", last_iss[0], 16);
        chk("nom_first1", first_iss[1], 29);
        chk("nom_last1", last_iss[1], 44);
        chk("nom_first2", first_iss[2], 57);
        chk("nom_last2", last_iss[2], 72);
        chk("nom_done_cyc", done_cyc, 85);
        chk("nom_busy_fall", busy_fall, 86);
        chk("nom_issues", n_iss, 48);
        chk("nom_err", err, 0);

        // stall in cycles 5..7
        reset_stats();
        step(1'b1, 1'b0, 1'b0);
        for (int c = 1; c < 100; c++) step(1'b0, (c >= 5 && c <= 7), 1'b0);
        chk("stl_grp5", grp_rec[5], 4);
        chk("stl_grp7", grp_rec[7], 4);
        chk("stl_last0", last_iss[0], 19);
        chk("stl_first1", first_iss[1], 32);
        chk("stl_issues", n_iss, 48);

        // issue/retire collision, pipeline depth 1
        dly = 1; reset_stats();
        step(1'b1, 1'b0, 1'b0);
        repeat (99) step(1'b0, 1'b0, 1'b0);
        chk("col_last0", last_iss[0], 16);
        chk("col_first1", first_iss[1], 18);
        chk("col_done_cyc", done_cyc, 52);
        chk("col_issues", n_iss, 48);

        // start while busy
        dly = 12; reset_stats();
        for (int c = 0; c < 100; c++) step((c == 0 || c == 10 || c == 40), 1'b0, 1'b0);
        chk("swb_done_cnt", n_done, 1);
        chk("swb_issues", n_iss, 48);
        chk("swb_first2", first_iss[2], 57);

        // randomized runs
        for (int r = 0; r < 8; r++) begin
            dly = $urandom_range(1, 20);
            reset_stats();
            for (int c = 0; c < 160; c++)
                step((c == 0) || ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0), 1'b0);
        end
        repeat (200) step(1'b0, ($urandom_range(0, 3) == 0), 1'b0);

        // protocol error: stray retire in IDLE, sticky across a run
        do_reset("pe_rst");
        dly = 12;
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk("pe_err_set", err, 1);
        reset_stats();
        step(1'b1, 1'b0, 1'b0);
        repeat (99) step(1'b0, 1'b0, 1'b0);
        chk("pe_done_cnt", n_done, 1);
        chk("pe_err_sticky", err, 1);
        do_reset("pe_clr");

        // reset mid-run during stage-0 drain
        reset_stats();
        step(1'b1, 1'b0, 1'b0);
        repeat (19) step(1'b0, 1'b0, 1'b0);
        do_reset("mid");
        repeat (30) step(1'b0, 1'b0, 1'b0);
        chk("mid_stale_err", err, 1);
        reset_stats();
        step(1'b1, 1'b0, 1'b0);
        repeat (99) step(1'b0, 1'b0, 1'b0);
        chk("mid_first0", first_iss[0], 1);
        chk("mid_grp1", grp_rec[1], 0);
        chk("mid_done_cnt", n_done, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ntt_stage_scheduler.md
# ntt_stage_scheduler

Sequencing controller for the radix-16 NTT index pipeline. It accepts a start request and issues one butterfly group per cycle for each stage. At each stage boundary it drains the index/enable delay pipeline so the next stage cannot read data that is still in flight. The issue strobe drives the delay pipeline's `ntt_enable` input, and the pipeline's delayed enable output comes back as the retire strobe.

## Interface
Parameters:
- `GRP_W`, default 4: log2 of groups per stage (16 groups).
- `STAGE_NUM`, default 3: number of NTT stages per run.
- `INFL_W`, default 5: width of the in-flight counter; must satisfy 2^INFL_W > 2^GRP_W.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: request a run; accepted only in IDLE.
- `stall`, in, 1: suppresses issue in the current cycle.
- `retire`, in, 1: one group has left the delay pipeline.
- `busy`, out, 1: high in every state except IDLE.
- `ntt_issue`, out, 1: issue strobe; goes to the delay pipeline's `ntt_enable`.
- `grp_idx`, out, GRP_W: group index of the current issue.
- `stage_idx`, out, $clog2(STAGE_NUM): current stage.
- `ntt_done`, out, 1: single-cycle pulse marking run completion.
- `err`, out, 1: sticky protocol-error flag.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- **IDLE**
  - `start`=1 goes to ISSUE.
  - `grp_idx` and `stage_idx` are cleared on entry to ISSUE from IDLE.
  - `start` in any other state is ignored.
- **ISSUE**
  - `ntt_issue` = !`stall`, combinational from state and `stall`.
  - `grp_idx` increments on each issue.
  - An issue with `grp_idx` = 2^GRP_W−1 goes to DRAIN, and `grp_idx` wraps to 0.
  - A stall holds `grp_idx` and the state.
- **In-flight counter** (INFL_W bits)
  - +1 on issue, −1 on retire; issue and retire in the same cycle leave it unchanged.
  - A retire while the counter is 0 sets `err` and the counter stays at 0.
  - An issue when the counter equals 2^INFL_W−1 sets `err` and the counter saturates.
- **DRAIN**
  - No issue is made.
  - Exit when the next counter value is 0, i.e. (count==1 && retire) or count==0.
  - Exit target: if `stage_idx` = STAGE_NUM−1, go to DONE; otherwise increment `stage_idx` and go to ISSUE.
- **DONE**
  - `ntt_done`=1 for exactly this one cycle.
  - Go to IDLE unconditionally; `stage_idx` is cleared to 0.
- `err` is cleared only by reset.
- `retire` in IDLE with count 0 also sets `err`.

## Timing
- **Reset values** (`rst` low, asynchronous): state IDLE; `busy`=0, `ntt_issue`=0, `grp_idx`=0, `stage_idx`=0, `ntt_done`=0, `err`=0; in-flight counter 0.
- **Reset mid-run:** asserting `rst` at any point aborts immediately to these values. Retires of groups that were in flight and arrive after reset release set `err`; this is expected.
- **Start latency:** `start` sampled high at edge t gives the first `ntt_issue` in cycle t+1.
- **Issue rate:** one group per non-stalled ISSUE cycle. A stage takes 2^GRP_W + stall cycles of issue.
- **Stage turnaround:** with the pipeline depth at 12, the last issue of a stage is at cycle c. Its retire arrives at c+12, and the next stage's first issue is at c+13. The next stage is not delayed further.
- **Done:** `ntt_done` is asserted the cycle after the final drain condition. `busy` falls one cycle after `ntt_done`.
- **Registered outputs:** `grp_idx`, `stage_idx`, `busy` and `ntt_done` are registered. `ntt_issue` is combinational from the state register and `stall`.

## Test plan
- **Nominal run.** Defaults; `retire` = `ntt_issue` delayed 12 cycles; `start` pulse at cycle 0.
  - Issues in cycles 1–16, 29–44 and 57–72, with `stage_idx` 0/1/2.
  - `ntt_done` in cycle 85; `busy` is 0 from cycle 86; `err`=0.
- **Stall.** Same run with `stall`=1 in cycles 5–7.
  - `grp_idx` holds at 4 across the stall.
  - Stage 0 ends at cycle 19 and stage 1 begins at 32.
  - Total issue count is exactly 48.
- **Issue/retire collision.** Pipeline delay of 1 during ISSUE, so issue and retire coincide every cycle.
  - Counter stays at 1 throughout.
  - DRAIN lasts one cycle and the next stage starts immediately.
- **Start while busy.** `start` pulses at cycles 0, 10 and 40.
  - Exactly one `ntt_done` pulse.
  - `grp_idx` sequence is undisturbed.
- **Protocol error.** `retire` pulse in IDLE.
  - `err`=1 and stays 1 through a later full run.
  - Cleared only by `rst`.
- **Reset mid-run.** `rst` low at cycle 20, during DRAIN of stage 0.
  - All outputs 0 in the same cycle.
  - A new `start` after release restarts from stage 0 with group 0.
